irq_dispatch: RTL and testbench
===============================

IRQ_DISPATCH -- requirements
Module: irq_dispatch

Interface
REQ-001 SHALL have parameter HOLDOFF, default 2: idle cycles after each acknowledge before the irq line is re-sampled; legal range 1..15.
REQ-002 SHALL have ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- irq  in  1  level interrupt from the interrupt controller, same clock domain.
- avl_address  out  1  word address: 0 = status, 1 = mask.
- avl_read  out  1  read strobe.
- avl_write  out  1  write strobe.
- avl_writedata  out  32  write data.
- avl_readdata  in  32  read data, valid in the cycle avl_read=1 and avl_waitrequest=0.
- avl_waitrequest  in  1  stall; the slave accepts a transfer in a cycle with waitrequest=0.
- core_irq_valid  out  1  an interrupt number is presented to the core.
- core_irq_num  out  5  index of the lowest set status bit.
- core_irq_pending  out  32  full status word captured by the last status read.
- core_irq_ack  in  1  core accepts the presented interrupt.
- core_mask_wr  in  1  core request to write the mask register.
- core_mask_data  in  32  mask value for core_mask_wr.
- core_mask_ready  out  1  a mask request is accepted this cycle.
- spurious_count  out  8  saturating count of status reads that returned 0.
REQ-003 SHALL use one clock (clk) and an asynchronous active-low reset (rst_n).

Function
REQ-004 SHALL implement FSM states IDLE, RD_STATUS, PRESENT, WR_MASK and HOLD.
REQ-005 In IDLE, core_mask_ready SHALL be 1; in all other states it SHALL be 0.
REQ-006 IDLE with core_mask_wr=1: latch core_mask_data into avl_writedata; next state WR_MASK. This takes priority over irq=1 in the same cycle.
REQ-007 IDLE with irq=1 and core_mask_wr=0: next state RD_STATUS.
REQ-008 RD_STATUS: avl_read=1 and avl_address=0 are driven, held stable until a cycle with avl_waitrequest=0.
REQ-009 On acceptance of the status read:
- capture avl_readdata into core_irq_pending.
- if the value is nonzero, core_irq_num = index of the lowest set bit; next state PRESENT.
- if the value is zero, spurious_count increments (saturating at 255); next state HOLD.
REQ-010 PRESENT: core_irq_valid=1 with core_irq_num and core_irq_pending stable; on core_irq_ack=1 go to HOLD. Ack outside PRESENT SHALL be ignored.
REQ-011 WR_MASK: avl_write=1, avl_address=1 and avl_writedata held stable until avl_waitrequest=0; next state IDLE.
REQ-012 HOLD: stay for exactly HOLDOFF cycles (4-bit down-counter), then go to IDLE; irq and core_mask_wr are ignored during HOLD.
REQ-013 avl_read and avl_write SHALL never both be 1.
REQ-014 Bus strobes and core_irq_valid SHALL be registered outputs with no combinational path from any input.
REQ-015 Latency: irq rising while idle -> avl_read=1 on the next cycle -> core_irq_valid=1 on the cycle after read acceptance (2 cycles minimum with waitrequest=0).
REQ-016 core_irq_num SHALL equal 0 whenever core_irq_pending is 0.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state IDLE.
- avl_read, avl_write, core_irq_valid = 0.
- avl_address = 0, avl_writedata = 0.
- core_irq_num = 0, core_irq_pending = 0, spurious_count = 0, HOLD counter = 0.
REQ-018 Reset asserted during a stalled bus transfer SHALL abort it; after release, no transfer is reissued unless a new trigger occurs.

Verification
REQ-019 Bench SHALL cover:
- irq=1, waitrequest=0, readdata=0x00000002 -> avl_read for 1 cycle at address 0; next cycle core_irq_valid=1, num=1, pending=0x2; ack -> HOLD for 2 cycles, then IDLE.
- readdata=0x00000003 with waitrequest=1 for 3 cycles -> avl_read held for 4 cycles with address stable; num=0.
- irq=1 and core_mask_wr=1 with data 0x3 in the same cycle -> mask write at address 1 with data 0x3 first; status read starts only after the write.
- irq=1, readdata=0 repeated 300 times -> spurious_count saturates at 255; core_irq_valid never asserts.
- rst_n pulsed low mid-RD_STATUS under waitrequest=1 -> avl_read drops asynchronously; all outputs at reset values; no read issued after release while irq=0.
- core_irq_ack=1 while in IDLE -> no state change.

Source files
------------

// File: rtl/irq_dispatch_if.sv
// rtl/irq_dispatch_if.sv - bus and core-side signal bundle for irq_dispatch
interface irq_dispatch_if;
  logic        irq;
  logic        avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [31:0] avl_readdata;
  logic        avl_waitrequest;
  logic        core_irq_valid;
  logic [4:0]  core_irq_num;
  logic [31:0] core_irq_pending;
  logic        core_irq_ack;
  logic        core_mask_wr;
  logic [31:0] core_mask_data;
  logic        core_mask_ready;
  logic [7:0]  spurious_count;

  modport master (
    input  irq, avl_readdata, avl_waitrequest, core_irq_ack, core_mask_wr, core_mask_data,
    output avl_address, avl_read, avl_write, avl_writedata,
           core_irq_valid, core_irq_num, core_irq_pending, core_mask_ready, spurious_count
  );

  modport slave (
    output irq, avl_readdata, avl_waitrequest, core_irq_ack, core_mask_wr, core_mask_data,
    input  avl_address, avl_read, avl_write, avl_writedata,
           core_irq_valid, core_irq_num, core_irq_pending, core_mask_ready, spurious_count
  );
endinterface

// File: rtl/irq_dispatch.sv
// rtl/irq_dispatch.sv - reads the interrupt status word over the bus and presents the lowest pending irq
module irq_dispatch #(
  parameter int unsigned HOLDOFF = 2
) (
  input logic            clk,
  input logic            rst_n,
  irq_dispatch_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_STATUS, PRESENT, WR_MASK, HOLD} state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);

  state_t      state_q;
  logic        rd_q;
  logic        wr_q;
  logic        addr_q;
  logic [31:0] wdata_q;
  logic        valid_q;
  logic [4:0]  num_q;
  logic [4:0]  num_d;
  logic [31:0] pending_q;
  logic [7:0]  spur_q;
  logic [3:0]  hold_q;

  // Lowest set bit wins; a zero word yields 0.
  always_comb begin
    num_d = '0;
    for (int i = 31; i >= 0; i--) begin
      if (bus.avl_readdata[i]) num_d = 5'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= 1'b0;
      wdata_q   <= '0;
      valid_q   <= 1'b0;
      num_q     <= '0;
      pending_q <= '0;
      spur_q    <= '0;
      hold_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.core_mask_wr) begin
            wdata_q <= bus.core_mask_data;
            addr_q  <= 1'b1;
            wr_q    <= 1'b1;
            state_q <= WR_MASK;
          end else if (bus.irq) begin
            addr_q  <= 1'b0;
            rd_q    <= 1'b1;
            state_q <= RD_STATUS;
          end
        end
        RD_STATUS: begin
          if (!bus.avl_waitrequest) begin
            rd_q      <= 1'b0;
            pending_q <= bus.avl_readdata;
            num_q     <= num_d;
            if (bus.avl_readdata != '0) begin
              valid_q <= 1'b1;
              state_q <= PRESENT;
            end else begin
              if (spur_q != 8'hFF) spur_q <= spur_q + 8'd1;
              hold_q  <= HOLD_INIT;
              state_q <= HOLD;
            end
          end
        end
        PRESENT: begin
          if (bus.core_irq_ack) begin
            valid_q <= 1'b0;
            hold_q  <= HOLD_INIT;
            state_q <= HOLD;
          end
        end
        WR_MASK: begin
          if (!bus.avl_waitrequest) begin
            wr_q    <= 1'b0;
            addr_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        HOLD: begin
          // hold_q counts the HOLD cycles still to spend, including this one.
          if (hold_q <= 4'd1) begin
            hold_q  <= '0;
            state_q <= IDLE;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.avl_read         = rd_q;
  assign bus.avl_write        = wr_q;
  assign bus.avl_address      = addr_q;
  assign bus.avl_writedata    = wdata_q;
  assign bus.core_irq_valid   = valid_q;
  assign bus.core_irq_num     = num_q;
  assign bus.core_irq_pending = pending_q;
  assign bus.spurious_count   = spur_q;
  assign bus.core_mask_ready  = (state_q == IDLE);
endmodule

// File: tb/tb_irq_dispatch.sv
// tb/tb_irq_dispatch.sv - self-checking bench for irq_dispatch
module tb_irq_dispatch;
  localparam int HOLDOFF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   exp_spur = 0;

  irq_dispatch_if bus ();

  irq_dispatch #(.HOLDOFF(HOLDOFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return 5'(i);
    return 5'd0;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold_phase(input bit poke);
    for (int h = 0; h < HOLDOFF; h++) begin
      chk("hold_ready", bus.core_mask_ready, 0);
      bus.irq          = poke;
      bus.core_mask_wr = poke;
      tick;
    end
    bus.irq          = 1'b0;
    bus.core_mask_wr = 1'b0;
    chk("hold_exit_ready", bus.core_mask_ready, 1);
    chk("hold_exit_strobes", {bus.avl_read, bus.avl_write}, 0);
  endtask

  task automatic do_irq(input logic [31:0] data, input int stalls, input int ackdly, input bit poke);
    bus.irq          = 1'b1;
    bus.avl_readdata = data;
    tick;
    bus.irq = 1'b0;
    for (int i = 0; i <= stalls; i++) begin
      chk("rd_strobe", bus.avl_read, 1);
      chk("rd_addr", bus.avl_address, 0);
      chk("rd_nowrite", bus.avl_write, 0);
      bus.avl_waitrequest = (i < stalls);
      tick;
    end
    bus.avl_waitrequest = 1'b0;
    chk("rd_done", bus.avl_read, 0);
    chk("pending", bus.core_irq_pending, data);
    chk("num", bus.core_irq_num, lowest(data));
    if (data != 0) begin
      chk("valid", bus.core_irq_valid, 1);
      for (int a = 0; a < ackdly; a++) begin
        bus.core_mask_wr = 1'b1;
        bus.avl_readdata = $urandom;
        tick;
        chk("present_valid", bus.core_irq_valid, 1);
        chk("present_pending", bus.core_irq_pending, data);
        chk("present_ready", bus.core_mask_ready, 0);
      end
      bus.core_mask_wr = 1'b0;
      bus.core_irq_ack = 1'b1;
      tick;
      bus.core_irq_ack = 1'b0;
      chk("ack_valid", bus.core_irq_valid, 0);
    end else begin
      chk("spur_valid", bus.core_irq_valid, 0);
      if (exp_spur < 255) exp_spur++;
      chk("spur_count", bus.spurious_count, exp_spur);
    end
    hold_phase(poke);
  endtask

  task automatic do_mask(input logic [31:0] data, input int stalls);
    chk("mask_ready_pre", bus.core_mask_ready, 1);
    bus.core_mask_wr   = 1'b1;
    bus.core_mask_data = data;
    tick;
    bus.core_mask_wr   = 1'b0;
    bus.core_mask_data = $urandom;
    for (int i = 0; i <= stalls; i++) begin
      chk("wr_strobe", bus.avl_write, 1);
      chk("wr_addr", bus.avl_address, 1);
      chk("wr_data", bus.avl_writedata, data);
      chk("wr_noread", bus.avl_read, 0);
      bus.avl_waitrequest = (i < stalls);
      tick;
    end
    bus.avl_waitrequest = 1'b0;
    chk("wr_done", bus.avl_write, 0);
    chk("wr_ready_post", bus.core_mask_ready, 1);
  endtask

  initial begin
    int accepts;
    int cyc;
    bit saw_valid;
    logic [31:0] d;

    bus.irq             = 1'b0;
    bus.avl_readdata    = '0;
    bus.avl_waitrequest = 1'b0;
    bus.core_irq_ack    = 1'b0;
    bus.core_mask_wr    = 1'b0;
    bus.core_mask_data  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_read", bus.avl_read, 0);
    chk("rst_write", bus.avl_write, 0);
    chk("rst_valid", bus.core_irq_valid, 0);
    chk("rst_pending", bus.core_irq_pending, 0);
    chk("rst_spur", bus.spurious_count, 0);
    chk("rst_ready", bus.core_mask_ready, 1);
    rst_n = 1'b1;
    tick;

    do_irq(32'h0000_0002, 0, 1, 0);
    do_irq(32'h0000_0003, 3, 0, 0);

    // Simultaneous mask request and irq: the write goes first.
    bus.irq            = 1'b1;
    bus.core_mask_wr   = 1'b1;
    bus.core_mask_data = 32'h3;
    tick;
    bus.core_mask_wr = 1'b0;
    chk("both_write", bus.avl_write, 1);
    chk("both_addr", bus.avl_address, 1);
    chk("both_wdata", bus.avl_writedata, 32'h3);
    chk("both_noread", bus.avl_read, 0);
    tick;
    chk("both_wr_done", bus.avl_write, 0);
    chk("both_idle_noread", bus.avl_read, 0);
    bus.avl_readdata = 32'h80;
    tick;
    bus.irq = 1'b0;
    chk("both_read", bus.avl_read, 1);
    chk("both_read_addr", bus.avl_address, 0);
    tick;
    chk("both_valid", bus.core_irq_valid, 1);
    chk("both_num", bus.core_irq_num, 7);
    bus.core_irq_ack = 1'b1;
    tick;
    bus.core_irq_ack = 1'b0;
    hold_phase(0);

    // Back-to-back zero status reads saturate the spurious counter.
    bus.irq          = 1'b1;
    bus.avl_readdata = '0;
    accepts   = 0;
    cyc       = 0;
    saw_valid = 1'b0;
    while (accepts < 300 && cyc < 3000) begin
      if (bus.core_irq_valid) saw_valid = 1'b1;
      if (bus.avl_read && !bus.avl_waitrequest) begin
        accepts++;
        if (exp_spur < 255) exp_spur++;
      end
      tick;
      cyc++;
    end
    bus.irq = 1'b0;
    chk("spur_accepts", accepts, 300);
    chk("spur_no_valid", saw_valid, 0);
    chk("spur_sat", bus.spurious_count, 255);
    chk("spur_model", bus.spurious_count, exp_spur);
    repeat (4) tick;
    chk("spur_idle", bus.core_mask_ready, 1);

    do_mask(32'hA5A5_0F0F, 1);

    // Asynchronous reset during a stalled status read.
    bus.irq             = 1'b1;
    bus.avl_waitrequest = 1'b1;
    tick;
    bus.irq = 1'b0;
    chk("arst_pre_read", bus.avl_read, 1);
    #2 rst_n = 1'b0;
    #1;
    exp_spur = 0;
    chk("arst_read", bus.avl_read, 0);
    chk("arst_write", bus.avl_write, 0);
    chk("arst_valid", bus.core_irq_valid, 0);
    chk("arst_addr", bus.avl_address, 0);
    chk("arst_wdata", bus.avl_writedata, 0);
    chk("arst_num", bus.core_irq_num, 0);
    chk("arst_pending", bus.core_irq_pending, 0);
    chk("arst_spur", bus.spurious_count, 0);
    @(negedge clk);
    rst_n               = 1'b1;
    bus.avl_waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("arst_no_reissue", bus.avl_read, 0);
    end

    // Acknowledge while idle is ignored.
    bus.core_irq_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_ack_ready", bus.core_mask_ready, 1);
      chk("idle_ack_valid", bus.core_irq_valid, 0);
      chk("idle_ack_read", bus.avl_read, 0);
    end
    bus.core_irq_ack = 1'b0;

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: d = '0;
        1: d = 32'h1 << $urandom_range(0, 31);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0)
        do_mask($urandom, $urandom_range(0, 3));
      else
        do_irq(d, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    do_irq(32'h0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
